// File: rtl/inv_sub_bytes_seq.sv
// AES decryption Inverse SubBytes stage: substitutes one 32-bit column per cycle
// through four shared inverse S-box lookups, with valid/ready handshakes on both sides.
module inv_sub_bytes_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state;
    logic [1:0]   col;
    logic [127:0] in_buf;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Column 0 occupies the most significant 32 bits of the state.
    always_comb begin
        col_in = in_buf[127:96];
        case (col)
            2'd0: col_in = in_buf[127:96];
            2'd1: col_in = in_buf[95:64];
            2'd2: col_in = in_buf[63:32];
            2'd3: col_in = in_buf[31:0];
            default: col_in = in_buf[127:96];
        endcase
    end

    assign col_out = {inv_sbox(col_in[31:24]), inv_sbox(col_in[23:16]),
                      inv_sbox(col_in[15:8]),  inv_sbox(col_in[7:0])};

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= 2'd0;
            in_buf    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_buf <= in_data;
                        col    <= 2'd0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    case (col)
                        2'd0: out_data[127:96] <= col_out;
                        2'd1: out_data[95:64]  <= col_out;
                        2'd2: out_data[63:32]  <= col_out;
                        2'd3: out_data[31:0]   <= col_out;
                        default: ;
                    endcase
                    col <= col + 2'd1;
                    if (col == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Same-cycle output and input transfer keeps throughput at one state per 5 cycles.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            in_buf <= in_data;
                            col    <= 2'd0;
                            state  <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq; the reference inverse S-box is computed from
// GF(2^8) inversion and the inverse affine transform rather than a lookup table.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_checks;
    int n_fail;

    inv_sub_bytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox_ref(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return ginv(t);
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_sbox_ref(s[127-8*k -: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept din, then count cycles until out_valid; leaves the block in DONE.
    task automatic do_one(input logic [127:0] din, output int lat);
        int w;
        in_valid = 1'b1;
        in_data  = din;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        step();
        in_valid = 1'b0;
        in_data  = rand128();
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        step();
        rst_n = 1'b1;

        // Reset while BUSY with a partially written output
        in_valid = 1'b1;
        in_data  = 128'h0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL busy_reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL busy_reset_out_data got=%h exp=0", out_data); end
        in_valid = 1'b1;
        in_data  = rand128();
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_out_valid got=%b exp=0", out_valid); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL release_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end

        // Reset while DONE
        do_one(rand128(), lat);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL done_before_reset got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0) begin
            n_fail++; $display("FAIL done_reset got out_valid=%b out_data=%h exp 0/0", out_valid, out_data);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_one({16{8'h63}}, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL latency_63 got=%0d exp=4", lat); end
        n_checks++;
        if (out_data !== 128'h0) begin n_fail++; $display("FAIL data_63 got=%h exp=0", out_data); end
        release_out();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_valid_clear got=%b exp=0", out_valid); end
        do_one({16{8'h00}}, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL latency_00 got=%0d exp=4", lat); end
        n_checks++;
        if (out_data !== {16{8'h52}}) begin n_fail++; $display("FAIL data_00 got=%h exp=%h", out_data, {16{8'h52}}); end
        release_out();
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] din;
        din = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
        do_one(din, lat);
        n_checks++;
        if (out_data !== 128'hbd6e7c3df2b5779e0b61216e8b10b689) begin
            n_fail++; $display("FAIL fips_c1 got=%h exp=bd6e7c3df2b5779e0b61216e8b10b689", out_data);
        end
        n_checks++;
        if (out_data !== ref_state(din)) begin n_fail++; $display("FAIL fips_model got=%h exp=%h", out_data, ref_state(din)); end
        release_out();
    endtask

    task automatic test_per_byte();
        int lat;
        logic [127:0] din;
        din = 128'h000102030405060708090a0b0c0d0e0f;
        do_one(din, lat);
        n_checks++;
        if (out_data[127:120] !== 8'h52 || out_data[119:112] !== 8'h09) begin
            n_fail++; $display("FAIL byte01 got=%h %h exp=52 09", out_data[127:120], out_data[119:112]);
        end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (out_data[127-8*k -: 8] !== inv_sbox_ref(k[7:0])) begin
                n_fail++; $display("FAIL byte%0d got=%h exp=%h", k, out_data[127-8*k -: 8], inv_sbox_ref(k[7:0]));
            end
        end
        release_out();
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] din;
        for (int i = 0; i < 6; i++) begin
            din = rand128();
            do_one(din, lat);
            n_checks++;
            if (lat !== 4 || out_data !== ref_state(din)) begin
                n_fail++; $display("FAIL random%0d got lat=%0d data=%h exp lat=4 data=%h", i, lat, out_data, ref_state(din));
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] din;
        logic [127:0] exp_d;
        din = rand128();
        exp_d = ref_state(din);
        do_one(din, lat);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = rand128();
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d) begin
                n_fail++;
                $display("FAIL stall%0d got v=%b rdy=%b d=%h exp v=1 rdy=0 d=%h", i, out_valid, in_ready, out_data, exp_d);
            end
            step();
        end
        in_valid = 1'b0;
        release_out();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== exp_d) begin
            n_fail++; $display("FAIL stall_release got v=%b d=%h exp v=0 d=%h", out_valid, out_data, exp_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] st[4];
        logic [127:0] expq[$];
        logic [127:0] e;
        int acc_cyc[$];
        int n_acc;
        int n_out;
        int cyc;
        logic acc;
        logic oxf;
        for (int i = 0; i < 4; i++) st[i] = rand128();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = st[0];
        n_acc = 0;
        n_out = 0;
        cyc   = 0;
        while (n_out < 4 && cyc < 100) begin
            acc = in_valid && in_ready;
            oxf = out_valid && out_ready;
            if (oxf) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra got=%h exp=none", out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL b2b_out%0d got=%h exp=%h", n_out, out_data, e); end
                end
                n_out++;
            end
            if (acc) begin
                expq.push_back(ref_state(in_data));
                acc_cyc.push_back(cyc);
                n_acc++;
            end
            step();
            cyc++;
            if (acc) begin
                if (n_acc < 4) in_data = st[n_acc];
                else begin
                    in_valid = 1'b0;
                    in_data  = rand128();
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_out !== 4 || n_acc !== 4) begin n_fail++; $display("FAIL b2b_counts got out=%0d acc=%0d exp 4/4", n_out, n_acc); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_checks++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin
                n_fail++; $display("FAIL b2b_interval%0d got=%0d exp=5", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        test_reset();
        test_basic();
        test_fips();
        test_per_byte();
        test_random();
        test_backpressure();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
